// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation codes,
// FSM states and the iteration counter sizing.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_RUN    = 2'b01;
    localparam logic [1:0] S_FINISH = 2'b10;

    // Counter must hold the value WIDTH itself, hence the extra bit.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/muldiv_unit_condneg.sv
// Combinational conditional two's-complement negate: o_y = i_neg ? -i_a : i_a.
module condneg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_y
);

    localparam logic [WIDTH-1:0] ONE = 1;

    assign o_y = i_neg ? ((~i_a) + ONE) : i_a;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit owning the HI and LO
// registers; busy stalls the pipeline while an operation is in flight.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             ph1,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_count;
    logic             r_is_div;
    logic             r_neg_res;
    logic             r_sign_a;
    logic             r_div0;
    logic [WIDTH-1:0] r_acc_hi;   // multiply: upper accumulator; divide: remainder
    logic [WIDTH-1:0] r_acc_lo;   // multiply: multiplier/low product; divide: quotient
    logic [WIDTH-1:0] r_mcand;    // multiplicand or divisor magnitude
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;

    logic               w_signed;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_no_borrow;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_neg_a  = w_signed & srca[WIDTH-1];
    assign w_neg_b  = w_signed & srcb[WIDTH-1];

    condneg #(.WIDTH(WIDTH)) u_mag_a (.i_a(srca), .i_neg(w_neg_a), .o_y(w_mag_a));
    condneg #(.WIDTH(WIDTH)) u_mag_b (.i_a(srcb), .i_neg(w_neg_b), .o_y(w_mag_b));

    condneg #(.WIDTH(2*WIDTH)) u_prod_fix (
        .i_a   ({r_acc_hi, r_acc_lo}),
        .i_neg (r_neg_res),
        .o_y   (w_prod)
    );
    // A zero divisor leaves the all-ones quotient un-negated; the remainder
    // then fixes back to the raw dividend.
    condneg #(.WIDTH(WIDTH)) u_quo_fix (.i_a(r_acc_lo), .i_neg(r_neg_res & ~r_div0), .o_y(w_quo));
    condneg #(.WIDTH(WIDTH)) u_rem_fix (.i_a(r_acc_hi), .i_neg(r_sign_a), .o_y(w_rem));

    // One multiply and one divide iteration step, both W+1 bits wide
    always_comb begin
        w_add       = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
        w_rem_sh    = {r_acc_hi, r_acc_lo[WIDTH-1]};
        w_diff      = w_rem_sh - {1'b0, r_mcand};
        w_no_borrow = w_rem_sh[WIDTH] | ~w_diff[WIDTH];
    end

    // FSM, iteration datapath and HI/LO architectural registers
    always_ff @(posedge ph1) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_sign_a  <= 1'b0;
            r_div0    <= 1'b0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_mcand   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mthi) r_hi <= wdata;
                    if (mtlo) r_lo <= wdata;
                    if (start) begin
                        r_state   <= S_RUN;
                        r_busy    <= 1'b1;
                        r_count   <= '0;
                        r_is_div  <= op[1];
                        r_neg_res <= w_neg_a ^ w_neg_b;
                        r_sign_a  <= w_neg_a;
                        r_div0    <= op[1] & (srcb == {WIDTH{1'b0}});
                        r_acc_hi  <= '0;
                        r_acc_lo  <= op[1] ? w_mag_a : w_mag_b;
                        r_mcand   <= op[1] ? w_mag_b : w_mag_a;
                    end
                end
                S_RUN: begin
                    r_count <= r_count + CNT_ONE;
                    if (r_is_div) begin
                        r_acc_hi <= w_no_borrow ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
                        r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_no_borrow};
                    end else begin
                        r_acc_hi <= w_add[WIDTH:1];
                        r_acc_lo <= {w_add[0], r_acc_lo[WIDTH-1:1]};
                    end
                    if (r_count == CNT_LAST) r_state <= S_FINISH;
                end
                S_FINISH: begin
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed results.
module tb_muldiv_unit;

    logic        ph1 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] srca = 32'h0;
    logic [31:0] srcb = 32'h0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_pass  = 0;
    int n_total = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .ph1(ph1), .reset(reset), .start(start), .op(op),
        .srca(srca), .srcb(srcb), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 ph1 = ~ph1;

    // Pulses start for one edge; returns at the negedge just after edge E.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge ph1);
        start = 1'b1; op = o; srca = a; srcb = b;
        @(negedge ph1);
        start = 1'b0;
    endtask

    // Counts negedges until done is seen (bounded); n = edges after E.
    task automatic wait_done(output int n, output bit seen);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 80) begin
            if (done === 1'b1) seen = 1'b1;
            else begin
                @(negedge ph1);
                n++;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge ph1);
        reset = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else n_pass++;
        n_total++; if (hi !== 32'h0) $display("FAIL reset_hi got %h want 00000000", hi); else n_pass++;
        n_total++; if (lo !== 32'h0) $display("FAIL reset_lo got %h want 00000000", lo); else n_pass++;
    endtask

    task automatic test_multu_max;
        int n; bit seen;
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_total++; if (busy !== 1'b1) $display("FAIL multu_busy_set got %0b want 1", busy); else n_pass++;
        n_total++; if (hi !== 32'h0) $display("FAIL multu_hi_hold got %h want 00000000", hi); else n_pass++;
        wait_done(n, seen);
        n_total++; if (!seen || n != 33) $display("FAIL multu_latency got %0d (seen %0b) want 33", n, seen); else n_pass++;
        n_total++; if (hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi got %h want fffffffe", hi); else n_pass++;
        n_total++; if (lo !== 32'h0000_0001) $display("FAIL multu_lo got %h want 00000001", lo); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL multu_busy_done got %0b want 0", busy); else n_pass++;
        @(negedge ph1);
        n_total++; if (done !== 1'b0) $display("FAIL multu_done_pulse got %0b want 0", done); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL multu_busy_after got %0b want 0", busy); else n_pass++;
    endtask

    task automatic test_signed;
        int n; bit seen;
        launch(2'b00, 32'hFFFF_FFFD, 32'h0000_0005);
        wait_done(n, seen);
        n_total++; if (!seen) $display("FAIL mult_done got 0 want 1"); else n_pass++;
        n_total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi got %h want ffffffff", hi); else n_pass++;
        n_total++; if (lo !== 32'hFFFF_FFF1) $display("FAIL mult_lo got %h want fffffff1", lo); else n_pass++;
        launch(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(n, seen);
        n_total++; if (!seen || n != 33) $display("FAIL div_latency got %0d (seen %0b) want 33", n, seen); else n_pass++;
        n_total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_lo got %h want fffffffd", lo); else n_pass++;
        n_total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_hi got %h want ffffffff", hi); else n_pass++;
    endtask

    task automatic test_div_edges;
        int n; bit seen;
        launch(2'b11, 32'h0000_0007, 32'h0000_0000);
        wait_done(n, seen);
        n_total++; if (!seen) $display("FAIL divu0_done got 0 want 1"); else n_pass++;
        n_total++; if (lo !== 32'hFFFF_FFFF) $display("FAIL divu0_lo got %h want ffffffff", lo); else n_pass++;
        n_total++; if (hi !== 32'h0000_0007) $display("FAIL divu0_hi got %h want 00000007", hi); else n_pass++;
        launch(2'b10, 32'hFFFF_FFF9, 32'h0000_0000);
        wait_done(n, seen);
        n_total++; if (lo !== 32'hFFFF_FFFF) $display("FAIL div0_signed_lo got %h want ffffffff", lo); else n_pass++;
        n_total++; if (hi !== 32'hFFFF_FFF9) $display("FAIL div0_signed_hi got %h want fffffff9", hi); else n_pass++;
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n, seen);
        n_total++; if (lo !== 32'h8000_0000) $display("FAIL divovf_lo got %h want 80000000", lo); else n_pass++;
        n_total++; if (hi !== 32'h0000_0000) $display("FAIL divovf_hi got %h want 00000000", hi); else n_pass++;
    endtask

    task automatic test_ignore_busy;
        int n; bit seen;
        launch(2'b01, 32'h0000_0003, 32'h0000_0004);
        repeat (4) @(negedge ph1);
        start = 1'b1; op = 2'b11; srca = 32'h0000_0063; srcb = 32'h0000_0001;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_DEAD;
        @(negedge ph1);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        n_total++; if (hi !== 32'h0) $display("FAIL busy_mthi_hi got %h want 00000000", hi); else n_pass++;
        n_total++; if (lo !== 32'h8000_0000) $display("FAIL busy_mtlo_lo got %h want 80000000", lo); else n_pass++;
        wait_done(n, seen);
        n_total++; if (!seen || n != 28) $display("FAIL busy_latency got %0d (seen %0b) want 28", n, seen); else n_pass++;
        n_total++; if (hi !== 32'h0) $display("FAIL busy_hi got %h want 00000000", hi); else n_pass++;
        n_total++; if (lo !== 32'h0000_000C) $display("FAIL busy_lo got %h want 0000000c", lo); else n_pass++;
        repeat (3) @(negedge ph1);
        n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL busy_no_queue got busy %0b done %0b want 0 0", busy, done); else n_pass++;
    endtask

    task automatic test_moves;
        int n; bit seen;
        @(negedge ph1);
        mthi = 1'b1; wdata = 32'h1234_5678;
        @(negedge ph1);
        mthi = 1'b0;
        n_total++; if (hi !== 32'h1234_5678) $display("FAIL mthi_hi got %h want 12345678", hi); else n_pass++;
        n_total++; if (lo !== 32'h0000_000C) $display("FAIL mthi_lo got %h want 0000000c", lo); else n_pass++;
        start = 1'b1; op = 2'b01; srca = 32'h2; srcb = 32'h2; mtlo = 1'b1;
        @(negedge ph1);
        start = 1'b0; mtlo = 1'b0;
        n_total++; if (lo !== 32'h1234_5678) $display("FAIL mtlo_start_lo got %h want 12345678", lo); else n_pass++;
        n_total++; if (hi !== 32'h1234_5678) $display("FAIL mtlo_start_hi got %h want 12345678", hi); else n_pass++;
        wait_done(n, seen);
        n_total++; if (hi !== 32'h0) $display("FAIL mtlo_result_hi got %h want 00000000", hi); else n_pass++;
        n_total++; if (lo !== 32'h4) $display("FAIL mtlo_result_lo got %h want 00000004", lo); else n_pass++;
        @(negedge ph1);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_0F0F;
        @(negedge ph1);
        mthi = 1'b0; mtlo = 1'b0;
        n_total++; if (hi !== 32'hA5A5_0F0F || lo !== 32'hA5A5_0F0F) $display("FAIL mthilo_both got %h %h want a5a50f0f a5a50f0f", hi, lo); else n_pass++;
    endtask

    task automatic test_abort;
        int n; bit seen;
        launch(2'b11, 32'd100, 32'd7);
        repeat (8) @(negedge ph1);
        n_total++; if (busy !== 1'b1) $display("FAIL abort_busy_mid got %0b want 1", busy); else n_pass++;
        reset = 1'b1;
        @(negedge ph1);
        reset = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL abort_busy got %0b want 0", busy); else n_pass++;
        n_total++; if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL abort_hilo got %h %h want 0 0", hi, lo); else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge ph1);
            if (done !== 1'b0) seen = 1'b1;
        end
        n_total++; if (seen) $display("FAIL abort_no_done got pulse want none"); else n_pass++;
        n_total++; if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL abort_hilo_late got %h %h want 0 0", hi, lo); else n_pass++;
        launch(2'b11, 32'd100, 32'd7);
        wait_done(n, seen);
        n_total++; if (!seen || n != 33) $display("FAIL rerun_latency got %0d (seen %0b) want 33", n, seen); else n_pass++;
        n_total++; if (lo !== 32'h0000_000E) $display("FAIL rerun_lo got %h want 0000000e", lo); else n_pass++;
        n_total++; if (hi !== 32'h0000_0002) $display("FAIL rerun_hi got %h want 00000002", hi); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_signed();
        test_div_edges();
        test_ignore_busy();
        test_moves();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the pipelined MIPS core.
- Sits downstream of the execute-stage operand muxes and consumes the forwarded srca/srcb.
- Owns the HI/LO architectural registers: MULT, MULTU, DIV, DIVU, MTHI, MTLO write them; MFHI/MFLO read them.
- Radix-2 shift-add multiply and restoring divide. busy drives the hazard unit's stall.

Parameters:
WIDTH, 32, operand and HI/LO width; cycle count in RUN equals WIDTH

Ports:
ph1  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high
start  input  1  launch operation; sampled only in IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
srca  input  WIDTH  multiplicand / dividend
srcb  input  WIDTH  multiplier / divisor
mthi  input  1  write wdata to HI (IDLE only)
mtlo  input  1  write wdata to LO (IDLE only)
wdata  input  WIDTH  MTHI/MTLO data
busy  output  1  operation in flight; stall MFHI/MFLO and new start
done  output  1  one-cycle pulse, HI/LO just updated
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset: state IDLE; hi=0, lo=0, busy=0, done=0; count=0. Reset overrides everything, including mid-operation: no done pulse and no HI/LO update from the aborted operation.
- States and transitions:
  - IDLE: start=1 at edge E captures op and the operand magnitudes. For signed ops, record sign_a, sign_b and take two's-complement magnitudes; unsigned ops store operands raw. Go to RUN with count=0.
  - RUN: one iteration per edge. count increments; after WIDTH iterations (edge E+WIDTH) go to FINISH.
    - Multiply: 2W-bit accumulator {acc_hi, acc_lo}. If multiplier LSB is set, add the multiplicand into acc_hi with carry out; shift right one.
    - Divide: restoring. Shift {rem, quo} left; trial-subtract the divisor from rem; on no borrow, keep the difference and set quo LSB.
  - FINISH (edge E+WIDTH+1): apply sign fixup, write hi/lo, go to IDLE.
    - MULT: if sign_a^sign_b, negate the 2W-bit product. hi = upper half, lo = lower half.
    - DIV: quotient negated if sign_a^sign_b; remainder takes the dividend's sign. lo = quotient, hi = remainder.
- Outputs:
  - busy=1 from after edge E through edge E+WIDTH+1; busy=0 in the cycle after FINISH.
  - done=1 for exactly the cycle following the FINISH edge.
  - Total latency start→result: WIDTH+1 edges (33 at default).
- Division by zero (srcb==0, DIV or DIVU): sign fixup skipped. lo=all ones, hi=srca raw. No exception.
- DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0. Falls out of the magnitude algorithm; no special case.
- start while busy: ignored, with no queueing.
- mthi/mtlo:
  - Honoured only in IDLE; take effect on that edge.
  - Ignored while busy.
  - Both may assert together, writing the same wdata to both.
- mthi/mtlo with start in the same IDLE cycle: the move writes on that edge; the operation result later overwrites both registers.
- hi/lo hold their values during RUN; they change only at FINISH, on MTHI/MTLO, or on reset.
- Widths: all internal adders are W+1 bits, with carry/borrow as the MSB. No X propagation out of hi/lo at any time after reset.

Decomposition:
- Package muldiv_pkg:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - state encoding IDLE, RUN, FINISH.
  - Count width, $clog2(WIDTH)+1.
- Sub-module condneg (parameter WIDTH): combinational conditional two's-complement negate, y = neg ? -a : a.
  - Instanced for operand magnitudes (twice, W bits).
  - Instanced for product fixup (2W bits).
  - Instanced for quotient and remainder fixup (W bits each).
- The remaining FSM and datapath stay in muldiv_unit.

Test Plan:
- MULTU srca=FFFFFFFF, srcb=FFFFFFFF → after 33 edges done=1 for one cycle; hi=FFFFFFFE, lo=00000001; busy low the next cycle.
- MULT srca=FFFFFFFD (−3), srcb=00000005 → hi=FFFFFFFF, lo=FFFFFFF1. Then DIV srca=FFFFFFF9 (−7), srcb=00000002 → lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU srca=00000007, srcb=0 → lo=FFFFFFFF, hi=00000007. DIV srca=80000000, srcb=FFFFFFFF → lo=80000000, hi=00000000.
- Start MULTU 3×4; at cycle 5 pulse start with other operands, and mthi/mtlo with wdata=DEAD → both ignored; result hi=0, lo=0000000C.
- In IDLE, assert mthi=1, wdata=12345678 → hi=12345678 next cycle, lo unchanged. Same cycle mtlo+start MULTU 2×2 → lo=wdata immediately, then hi=0, lo=4 at done.
- Start DIVU 100/7, assert reset at cycle 10 → next cycle busy=0, hi=lo=0; no done pulse ever. A new start after reset completes normally: lo=0000000E, hi=00000002.
